// File: rtl/pong_text_overlay_if.sv
// -----------------------------------------------------------------------------
// pong_text_overlay_if
// Bundles the signals between the pong_text_overlay block and the logic around
// it: the tile generator, the game logic and the font ROM.
//   master : drives frame_tick, tile_x/tile_y, point_l/point_r and cd_start,
//            and receives char_adr and the game-flow status.
//   slave  : the overlay generator itself.
// -----------------------------------------------------------------------------
interface pong_text_overlay_if;
  logic       frame_tick;  // one-cycle pulse per video frame
  logic [6:0] tile_x;      // tile column 0..79
  logic [5:0] tile_y;      // tile row 0..29
  logic       point_l;     // left player scored (pulse)
  logic       point_r;     // right player scored (pulse)
  logic       cd_start;    // start / restart the game (pulse)
  logic [6:0] char_adr;    // ASCII code to the font ROM, registered
  logic       cd_active;   // countdown running
  logic       serve;       // ball release strobe (pulse)
  logic       game_over;   // OVER state
  logic       winner;      // 0 = left, 1 = right; valid with game_over

  modport master (
    output frame_tick, tile_x, tile_y, point_l, point_r, cd_start,
    input  char_adr, cd_active, serve, game_over, winner
  );

  modport slave (
    input  frame_tick, tile_x, tile_y, point_l, point_r, cd_start,
    output char_adr, cd_active, serve, game_over, winner
  );
endinterface

// File: rtl/pong_text_overlay.sv
// -----------------------------------------------------------------------------
// pong_text_overlay
// Maps the current 80x30 tile coordinate to an ASCII code for the font ROM and
// sequences the game flow: BCD score counters, a frame-timed serve countdown
// and a blinking GAME OVER banner.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low reset
//   bus   : pong_text_overlay_if.slave (tile coordinate, frame/point/start
//           pulses in; char_adr, cd_active, serve, game_over, winner out)
// -----------------------------------------------------------------------------
module pong_text_overlay #(
  parameter int DIGITS       = 2,
  parameter int WIN_SCORE    = 11,
  parameter int CD_START     = 3,
  parameter int CD_FRAMES    = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  pong_text_overlay_if.slave   bus
);

  typedef enum logic [1:0] {ST_READY, ST_COUNT, ST_PLAY, ST_OVER} state_e;

  localparam int SW = 4 * DIGITS;
  typedef logic [SW-1:0] score_t;

  function automatic score_t to_bcd(input int v);
    score_t r;
    int     n;
    r = '0;
    n = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  localparam score_t     WIN_BCD    = to_bcd(WIN_SCORE);
  localparam score_t     ALL_NINES  = to_bcd(10 ** DIGITS - 1);
  localparam logic [3:0] CD_FIRST   = 4'(CD_START);
  localparam logic [7:0] CD_LAST    = 8'(CD_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam int         R_LBL      = 73 - DIGITS;  // right "SCORE:" column
  localparam int         R_DIG      = 79 - DIGITS;  // right score MSD column

  localparam logic [71:0] TXT_TITLE = "PING-PONG";
  localparam logic [71:0] TXT_OVER  = "GAME OVER";
  localparam logic [47:0] TXT_SCORE = "SCORE:";

  // Ripple-carry BCD increment that sticks at all nines instead of wrapping.
  function automatic score_t bcd_inc(input score_t s);
    score_t r;
    logic   carry;
    r     = s;
    carry = 1'b1;
    if (s != ALL_NINES) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Digit idx (0 = least significant) as ASCII; leading zeros blank, LSD always shown.
  function automatic logic [6:0] digit_char(input score_t s, input int idx);
    logic shown;
    shown = (idx == 0);
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= idx && s[4*j +: 4] != 4'd0) shown = 1'b1;
    end
    return shown ? 7'd48 + {3'b000, s[4*idx +: 4]} : 7'd0;
  endfunction

  state_e     state_q,     state_d;
  logic [3:0] cd_val_q,    cd_val_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_on_q,  blink_on_d;
  score_t     score_l_q,   score_l_d;
  score_t     score_r_q,   score_r_d;
  logic       winner_q,    winner_d;
  logic       serve_q,     serve_d;
  logic       cd_active_q, cd_active_d;
  logic       game_over_q, game_over_d;
  logic [6:0] char_adr_q,  char_adr_d;
  score_t     new_score;

  // Game-flow FSM, blink timer and state-derived outputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d     = state_q;
    cd_val_d    = cd_val_q;
    frame_cnt_d = frame_cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    serve_d     = 1'b0;
    blink_on_d  = blink_on_q;
    blink_cnt_d = blink_cnt_q;
    new_score   = '0;

    case (state_q)
      ST_READY: begin
        if (bus.cd_start) begin
          state_d     = ST_COUNT;
          cd_val_d    = CD_FIRST;
          frame_cnt_d = '0;
        end
      end
      ST_COUNT: begin
        if (bus.frame_tick) begin
          if (frame_cnt_q == CD_LAST) begin
            frame_cnt_d = '0;
            if (cd_val_q == 4'd1) begin
              state_d = ST_PLAY;
              serve_d = 1'b1;
            end else begin
              cd_val_d = cd_val_q - 4'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        if (bus.point_l || bus.point_r) begin
          // Left wins a simultaneous pair of point pulses.
          new_score = bus.point_l ? bcd_inc(score_l_q) : bcd_inc(score_r_q);
          if (bus.point_l) score_l_d = new_score;
          else             score_r_d = new_score;
          if (new_score == WIN_BCD) begin
            state_d  = ST_OVER;
            winner_d = !bus.point_l;
          end else begin
            state_d     = ST_COUNT;
            cd_val_d    = CD_FIRST;
            frame_cnt_d = '0;
          end
        end
      end
      ST_OVER: begin
        if (bus.cd_start) begin
          state_d     = ST_COUNT;
          cd_val_d    = CD_FIRST;
          frame_cnt_d = '0;
          score_l_d   = '0;
          score_r_d   = '0;
          winner_d    = 1'b0;
        end
      end
      default: state_d = ST_READY;
    endcase

    // Blink only runs while staying in OVER, so a tick on the entry edge is not counted.
    if (state_q == ST_OVER && state_d == ST_OVER) begin
      if (bus.frame_tick) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_on_d  = !blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 8'd1;
        end
      end
    end else begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end

    cd_active_d = (state_d == ST_COUNT);
    game_over_d = (state_d == ST_OVER);
  end

  // Tile-to-character lookup from the current (registered) game state.
  always_comb begin
    char_adr_d = '0;
    if (bus.tile_y == 6'd1) begin
      for (int i = 0; i < 9; i++) begin
        if (bus.tile_x == 7'(33 + i)) char_adr_d = 7'(TXT_TITLE[8*(8-i) +: 8]);
      end
      for (int i = 0; i < 6; i++) begin
        if (bus.tile_x == 7'(1 + i))     char_adr_d = 7'(TXT_SCORE[8*(5-i) +: 8]);
        if (bus.tile_x == 7'(R_LBL + i)) char_adr_d = 7'(TXT_SCORE[8*(5-i) +: 8]);
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (bus.tile_x == 7'(7 + i))     char_adr_d = digit_char(score_l_q, DIGITS - 1 - i);
        if (bus.tile_x == 7'(R_DIG + i)) char_adr_d = digit_char(score_r_q, DIGITS - 1 - i);
      end
    end
    if (bus.tile_y == 6'd15) begin
      if (state_q == ST_COUNT && (bus.tile_x == 7'd35 || bus.tile_x == 7'd44)) begin
        char_adr_d = 7'd48 + {3'b000, cd_val_q};
      end
      if (state_q == ST_OVER && blink_on_q) begin
        for (int i = 0; i < 9; i++) begin
          if (bus.tile_x == 7'(35 + i)) char_adr_d = 7'(TXT_OVER[8*(8-i) +: 8]);
        end
      end
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_READY;
      cd_val_q    <= '0;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= 1'b0;
      serve_q     <= 1'b0;
      cd_active_q <= 1'b0;
      game_over_q <= 1'b0;
      char_adr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cd_val_q    <= cd_val_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      serve_q     <= serve_d;
      cd_active_q <= cd_active_d;
      game_over_q <= game_over_d;
      char_adr_q  <= char_adr_d;
    end
  end

  assign bus.char_adr  = char_adr_q;
  assign bus.cd_active = cd_active_q;
  assign bus.serve     = serve_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_pong_text_overlay.sv
// -----------------------------------------------------------------------------
// tb_pong_text_overlay
// Two instances: A (DIGITS=2, WIN_SCORE=11, CD_START=3, CD_FRAMES=2,
// BLINK_FRAMES=1) and B (DIGITS=1, WIN_SCORE=9, CD_START=1, CD_FRAMES=1,
// BLINK_FRAMES=1). Stimulus pushes expected {char_adr, flags} into a queue
// when it issues a lookup; a monitor pops and compares one cycle later.
// Flags are packed {cd_active, serve, game_over, winner}.
// -----------------------------------------------------------------------------
module tb_pong_text_overlay;

  typedef struct {
    int    dut;
    string name;
    int    ch;
    int    fl;
  } exp_t;

  localparam int F_READY  = 0;
  localparam int F_PLAY   = 0;
  localparam int F_COUNT  = 8;
  localparam int F_SERVE  = 4;
  localparam int F_OVER_L = 2;
  localparam int F_OVER_R = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, pl_a, pr_a, cs_a, pl_b, pr_b, cs_b;
  logic       probe, probe_q;
  logic [6:0] tile_x;
  logic [5:0] tile_y;

  int   tests = 0;
  int   fails = 0;
  int   serve_cnt_a = 0, serve_cnt_b = 0;
  int   exp_serve_a = 0, exp_serve_b = 0;
  exp_t sb_q[$];

  pong_text_overlay_if a_if ();
  pong_text_overlay_if b_if ();

  assign a_if.tile_x     = tile_x;
  assign a_if.tile_y     = tile_y;
  assign a_if.frame_tick = frame_tick;
  assign a_if.point_l    = pl_a;
  assign a_if.point_r    = pr_a;
  assign a_if.cd_start   = cs_a;
  assign b_if.tile_x     = tile_x;
  assign b_if.tile_y     = tile_y;
  assign b_if.frame_tick = frame_tick;
  assign b_if.point_l    = pl_b;
  assign b_if.point_r    = pr_b;
  assign b_if.cd_start   = cs_b;

  pong_text_overlay #(
    .DIGITS(2), .WIN_SCORE(11), .CD_START(3), .CD_FRAMES(2), .BLINK_FRAMES(1)
  ) u_a (
    .clk(clk), .reset(reset), .bus(a_if)
  );

  pong_text_overlay #(
    .DIGITS(1), .WIN_SCORE(9), .CD_START(1), .CD_FRAMES(1), .BLINK_FRAMES(1)
  ) u_b (
    .clk(clk), .reset(reset), .bus(b_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Inputs set before step() are sampled at the next rising edge, then cleared.
  task automatic step();
    @(negedge clk);
    frame_tick = 1'b0;
    pl_a = 1'b0; pr_a = 1'b0; cs_a = 1'b0;
    pl_b = 1'b0; pr_b = 1'b0; cs_b = 1'b0;
    probe = 1'b0;
  endtask

  task automatic expect_at(input int dut, input int x, input int y, input int ch,
                           input int fl, input string nm);
    exp_t e;
    tile_x = 7'(x);
    tile_y = 6'(y);
    probe  = 1'b1;
    e.dut  = dut;
    e.name = $sformatf("%s_%s(%0d,%0d)", nm, (dut == 0) ? "a" : "b", x, y);
    e.ch   = ch;
    e.fl   = fl;
    sb_q.push_back(e);
  endtask

  // Full countdown on A: CD_START=3 x CD_FRAMES=2 = 6 ticks, each followed by an
  // idle cycle. With disturb, ignored cd_start/point_r pulses are injected mid-way.
  task automatic countdown_a(input bit disturb);
    for (int k = 1; k <= 6; k++) begin
      frame_tick = 1'b1;
      step();
      step();
      if (disturb && k == 3) begin
        cs_a = 1'b1;
        pr_a = 1'b1;
        step();
      end
    end
    exp_serve_a++;
  endtask

  // Row 1 in READY for DIGITS=2, all scores zero.
  function automatic int row1_ready(input int x);
    case (x)
      1: return 83;  2: return 67;  3: return 79;  4: return 82;  5: return 69;  6: return 58;
      8: return 48;
      33: return 80; 34: return 73; 35: return 78; 36: return 71; 37: return 45;
      38: return 80; 39: return 79; 40: return 78; 41: return 71;
      71: return 83; 72: return 67; 73: return 79; 74: return 82; 75: return 69; 76: return 58;
      78: return 48;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) probe_q <= probe;

  // Scoreboard monitor: a lookup issued at edge t is compared after edge t.
  always @(negedge clk) begin
    exp_t e;
    int   ach, afl;
    if (probe_q) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        if (e.dut == 0) begin
          ach = int'(a_if.char_adr);
          afl = int'({a_if.cd_active, a_if.serve, a_if.game_over, a_if.winner});
        end else begin
          ach = int'(b_if.char_adr);
          afl = int'({b_if.cd_active, b_if.serve, b_if.game_over, b_if.winner});
        end
        check({e.name, "_char"}, ach, e.ch);
        check({e.name, "_flags"}, afl, e.fl);
      end
    end
  end

  always @(negedge clk) begin
    if (a_if.serve === 1'b1) serve_cnt_a++;
    if (b_if.serve === 1'b1) serve_cnt_b++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    frame_tick = 1'b0;
    pl_a = 1'b0; pr_a = 1'b0; cs_a = 1'b0;
    pl_b = 1'b0; pr_b = 1'b0; cs_b = 1'b0;
    probe = 1'b0;
    tile_x = '0;
    tile_y = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // READY: sweep every tile.
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 80; x++) begin
        expect_at(0, x, y, (y == 1) ? row1_ready(x) : 0, F_READY, "sweep");
        step();
      end
    end
    check("serve_ready_a", serve_cnt_a, 0);

    // Countdown 3,2,1 with two frames per digit.
    cs_a = 1'b1;
    step();
    expect_at(0, 35, 15, 51, F_COUNT, "cd_entry"); step();
    expect_at(0, 44, 15, 51, F_COUNT, "cd_entry"); step();
    begin
      int cd_exp[5] = '{51, 50, 50, 49, 49};
      for (int k = 0; k < 5; k++) begin
        frame_tick = 1'b1;
        step();
        expect_at(0, 35, 15, cd_exp[k], F_COUNT, $sformatf("cd_tick%0d", k + 1));
        step();
      end
    end
    frame_tick = 1'b1;
    expect_at(0, 35, 15, 49, F_SERVE, "cd_tick6");
    step();
    exp_serve_a++;
    expect_at(0, 35, 15, 0, F_PLAY, "serve_drop");
    step();
    check("serve_once_a", serve_cnt_a, exp_serve_a);

    // Simultaneous points: only the left one counts.
    pl_a = 1'b1; pr_a = 1'b1;
    step();
    expect_at(0, 8, 1, 49, F_COUNT, "both_l");  step();
    expect_at(0, 78, 1, 48, F_COUNT, "both_r"); step();
    countdown_a(1'b1);
    expect_at(0, 78, 1, 48, F_PLAY, "ignored_r"); step();
    check("serve_disturb_a", serve_cnt_a, exp_serve_a);

    // Left points 2..9, then 10.
    for (int i = 2; i <= 9; i++) begin
      pl_a = 1'b1;
      step();
      expect_at(0, 7, 1, 0, F_COUNT, $sformatf("left%0d_msd", i));      step();
      expect_at(0, 8, 1, 48 + i, F_COUNT, $sformatf("left%0d_lsd", i)); step();
      countdown_a(1'b0);
    end
    pl_a = 1'b1;
    step();
    expect_at(0, 7, 1, 49, F_COUNT, "left10_msd"); step();
    expect_at(0, 8, 1, 48, F_COUNT, "left10_lsd"); step();
    countdown_a(1'b0);

    // Right player reaches 11.
    for (int j = 1; j <= 10; j++) begin
      pr_a = 1'b1;
      step();
      countdown_a(1'b0);
    end
    expect_at(0, 77, 1, 49, F_PLAY, "right10_msd"); step();
    expect_at(0, 78, 1, 48, F_PLAY, "right10_lsd"); step();
    pr_a = 1'b1;
    step();
    expect_at(0, 78, 1, 49, F_OVER_R, "right11");    step();
    expect_at(0, 8, 1, 48, F_OVER_R, "over_left");   step();
    check("serve_game_a", serve_cnt_a, exp_serve_a);

    // Blink with one frame per half-period.
    expect_at(0, 35, 15, 71, F_OVER_R, "blink_on0");  step();
    expect_at(0, 39, 15, 32, F_OVER_R, "blink_on0");  step();
    frame_tick = 1'b1; step();
    expect_at(0, 35, 15, 0, F_OVER_R, "blink_off1");  step();
    frame_tick = 1'b1; step();
    expect_at(0, 43, 15, 82, F_OVER_R, "blink_on2");  step();
    frame_tick = 1'b1; step();
    expect_at(0, 43, 15, 0, F_OVER_R, "blink_off3");  step();
    pl_a = 1'b1; step();
    expect_at(0, 8, 1, 48, F_OVER_R, "over_ignore");  step();

    // Restart clears scores and winner.
    cs_a = 1'b1;
    step();
    expect_at(0, 7, 1, 0, F_COUNT, "restart_l_msd");  step();
    expect_at(0, 8, 1, 48, F_COUNT, "restart_l_lsd"); step();
    expect_at(0, 78, 1, 48, F_COUNT, "restart_r");    step();
    expect_at(0, 35, 15, 51, F_COUNT, "restart_cd");  step();
    countdown_a(1'b0);

    // Reset in COUNT with cd_val = 2 and a nonzero left score.
    pl_a = 1'b1; step();
    frame_tick = 1'b1; step(); step();
    frame_tick = 1'b1; step(); step();
    expect_at(0, 35, 15, 50, F_COUNT, "pre_reset_cd"); step();
    reset = 1'b0; cs_a = 1'b1;
    step();
    reset = 1'b1;
    expect_at(0, 8, 1, 48, F_READY, "rst_count_score"); step();
    expect_at(0, 35, 15, 0, F_READY, "rst_count_cd");   step();
    step();
    check("serve_rst_a", serve_cnt_a, exp_serve_a);

    // Instance B: single digit, saturation at '9' into OVER.
    cs_b = 1'b1; step();
    expect_at(1, 35, 15, 49, F_COUNT, "b_cd"); step();
    frame_tick = 1'b1; step();
    exp_serve_b++;
    expect_at(1, 7, 1, 48, F_PLAY, "b_play"); step();
    for (int i = 1; i <= 8; i++) begin
      pl_b = 1'b1; step();
      expect_at(1, 7, 1, 48 + i, F_COUNT, $sformatf("b_left%0d", i)); step();
      frame_tick = 1'b1; step(); step();
      exp_serve_b++;
    end
    pl_b = 1'b1; step();
    expect_at(1, 7, 1, 57, F_OVER_L, "b_left9"); step();
    pl_b = 1'b1; step();
    expect_at(1, 7, 1, 57, F_OVER_L, "b_sat");   step();
    expect_at(1, 72, 1, 83, F_OVER_L, "b_lbl");  step();
    expect_at(1, 71, 1, 0, F_OVER_L, "b_gap");   step();
    expect_at(1, 78, 1, 48, F_OVER_L, "b_rdig"); step();
    expect_at(1, 8, 1, 0, F_OVER_L, "b_gap");    step();
    check("serve_b", serve_cnt_b, exp_serve_b);

    // Reset in OVER, with cd_start held at the same edge.
    reset = 1'b0; cs_b = 1'b1;
    step();
    reset = 1'b1;
    expect_at(1, 7, 1, 48, F_READY, "rst_over_score"); step();
    expect_at(1, 35, 15, 0, F_READY, "rst_over_ban");  step();
    expect_at(0, 8, 1, 48, F_READY, "rst_over_a");     step();
    step();
    check("serve_rst_b", serve_cnt_b, exp_serve_b);

    step();
    step();
    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
